mmio_responder: RTL and testbench

Memory-mapped I/O responder sitting on the data-memory port of the pipelined MIPS core, in parallel with the data RAM. It decodes the core's memory-stage address, serves loads and stores to a small register window, and drives the board LEDs. The window also exposes debounced switches and a 32-bit compare timer with an interrupt flag. Read data is registered, so it returns in the write-back stage exactly like RAM read data; the top level muxes RAM versus I/O data using `IoSel`.

---
 rtl/mmio_responder.sv | 148 ++++++++++++++
 tb/tb_mmio_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped I/O window on the core's data port: LED register, debounced
// switches and a 32-bit compare timer, with read data registered like RAM.
module mmio_responder #(
    parameter logic [31:0] IO_BASE         = 32'h0000_FF00,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] DmemAddr,
    input  logic        DmemWrite,
    input  logic [31:0] DmemWrData,
    output logic [31:0] DmemRdData,
    output logic        IoSel,
    input  logic [7:0]  Switch,
    output logic [7:0]  Led,
    output logic        TimerIrq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 8;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned WORD_W = 6;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [WORD_W-1:0] REG_LED    = 6'h00;
    localparam logic [WORD_W-1:0] REG_SWITCH = 6'h01;
    localparam logic [WORD_W-1:0] REG_COUNT  = 6'h02;
    localparam logic [WORD_W-1:0] REG_CMP    = 6'h03;
    localparam logic [WORD_W-1:0] REG_CTRL   = 6'h04;
    localparam logic [WORD_W-1:0] REG_STATUS = 6'h05;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic              hit;
    logic              wr_en;
    logic [WORD_W-1:0] word;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              io_sel_d, io_sel_q;
    logic [SW_W-1:0]   led_d, led_q;
    logic [DATA_W-1:0] count_d, count_q;
    logic [DATA_W-1:0] cmp_d, cmp_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              match_d, match_q;
    logic [SW_W-1:0]   sync1_d, sync1_q;
    logic [SW_W-1:0]   sync2_d, sync2_q;
    logic [CNT_W-1:0]  stable_d, stable_q;
    logic [SW_W-1:0]   deb_d, deb_q;

    assign hit              = (DmemAddr[31:8] == IO_BASE[31:8]);
    assign wr_en            = hit & DmemWrite;
    assign word             = DmemAddr[7:2];
    assign unused_addr_bits = ^DmemAddr[1:0];

    // Load data: sampled from pre-write register values on every access
    always_comb begin
        rd_data_d = '0;
        io_sel_d  = hit;
        if (hit) begin
            case (word)
                REG_LED:    rd_data_d = {24'h0, led_q};
                REG_SWITCH: rd_data_d = {24'h0, deb_q};
                REG_COUNT:  rd_data_d = count_q;
                REG_CMP:    rd_data_d = cmp_q;
                REG_CTRL:   rd_data_d = {29'h0, ctrl_q};
                REG_STATUS: rd_data_d = {31'h0, match_q};
                default:    rd_data_d = '0;
            endcase
        end
    end

    // Timer and software stores; a COUNT store overrides the timer, a match beats W1C
    always_comb begin
        led_d   = led_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        if (wr_en && (word == REG_STATUS) && DmemWrData[0]) begin
            match_d = 1'b0;
        end
        if (ctrl_q[0]) begin
            if (count_q == cmp_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[1] ? '0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        if (wr_en) begin
            case (word)
                REG_LED:   led_d   = DmemWrData[SW_W-1:0];
                REG_COUNT: count_d = DmemWrData;
                REG_CMP:   cmp_d   = DmemWrData;
                REG_CTRL:  ctrl_d  = DmemWrData[CTRL_W-1:0];
                default:   ;
            endcase
        end
    end

    // Stability is judged on the value about to enter the second synchronizer stage
    always_comb begin
        sync1_d  = Switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        if (sync1_q != sync2_q) begin
            stable_d = '0;
        end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + CNT_W'(1);
        end
        deb_d = (stable_d == STABLE_MAX) ? sync2_q : deb_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_data_q <= '0;
            io_sel_q  <= 1'b0;
            led_q     <= '0;
            count_q   <= '0;
            cmp_q     <= 32'hFFFF_FFFF;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            deb_q     <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            io_sel_q  <= io_sel_d;
            led_q     <= led_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            deb_q     <= deb_d;
        end
    end

    assign DmemRdData = rd_data_q;
    assign IoSel      = io_sel_q;
    assign Led        = led_q;
    assign TimerIrq   = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus random traffic
// compared every cycle against a register-level behavioural model.
module tb_mmio_responder;

    localparam logic [31:0] BASE     = 32'h0000_FF00;
    localparam int unsigned DEB      = 16;
    localparam logic [31:0] A_LED    = BASE + 32'h00;
    localparam logic [31:0] A_SWITCH = BASE + 32'h04;
    localparam logic [31:0] A_COUNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP    = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL   = BASE + 32'h10;
    localparam logic [31:0] A_STATUS = BASE + 32'h14;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] DmemAddr = '0;
    logic        DmemWrite = 1'b0;
    logic [31:0] DmemWrData = '0;
    logic [31:0] DmemRdData;
    logic        IoSel;
    logic [7:0]  Switch = '0;
    logic [7:0]  Led;
    logic        TimerIrq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_led, m_deb;
    logic [31:0] m_count, m_cmp, m_rd;
    logic [2:0]  m_ctrl;
    logic        m_match, m_iosel;
    logic [7:0]  hist[$];

    mmio_responder #(
        .IO_BASE         (BASE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .DmemAddr   (DmemAddr),
        .DmemWrite  (DmemWrite),
        .DmemWrData (DmemWrData),
        .DmemRdData (DmemRdData),
        .IoSel      (IoSel),
        .Switch     (Switch),
        .Led        (Led),
        .TimerIrq   (TimerIrq)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_led   = '0;
        m_count = '0;
        m_cmp   = 32'hFFFF_FFFF;
        m_ctrl  = '0;
        m_match = 1'b0;
        m_deb   = '0;
        m_rd    = '0;
        m_iosel = 1'b0;
        hist.delete();
        hist.push_back(8'h00);
        hist.push_back(8'h00);
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00:   return {24'h0, m_led};
            8'h04:   return {24'h0, m_deb};
            8'h08:   return m_count;
            8'h0C:   return m_cmp;
            8'h10:   return {29'h0, m_ctrl};
            8'h14:   return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: predict from current inputs, advance, compare visible outputs
    task automatic step();
        logic        hit, wr, stable, n_match;
        logic [7:0]  off, n_led, n_deb;
        logic [31:0] n_count, n_cmp, n_rd;
        logic [2:0]  n_ctrl;
        hit     = (DmemAddr[31:8] == BASE[31:8]);
        wr      = hit && DmemWrite;
        off     = {DmemAddr[7:2], 2'b00};
        n_rd    = hit ? m_read(off) : 32'h0;
        n_led   = m_led;
        n_count = m_count;
        n_cmp   = m_cmp;
        n_ctrl  = m_ctrl;
        n_match = m_match;
        if (wr && off == 8'h14 && DmemWrData[0]) n_match = 1'b0;
        if (m_ctrl[0]) begin
            if (m_count == m_cmp) begin
                n_match = 1'b1;
                n_count = m_ctrl[1] ? 32'h0 : m_count + 32'd1;
            end else begin
                n_count = m_count + 32'd1;
            end
        end
        if (wr) begin
            case (off)
                8'h00:   n_led   = DmemWrData[7:0];
                8'h08:   n_count = DmemWrData;
                8'h0C:   n_cmp   = DmemWrData;
                8'h10:   n_ctrl  = DmemWrData[2:0];
                default: ;
            endcase
        end
        // Switch value is accepted once the last DEB+1 samples all agree
        n_deb  = m_deb;
        stable = (hist.size() == DEB + 1);
        foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
        if (stable) n_deb = hist[0];
        hist.push_back(Switch);
        if (hist.size() > DEB + 1) void'(hist.pop_front());

        @(posedge Clk);
        #1;
        m_rd    = n_rd;
        m_iosel = hit;
        m_led   = n_led;
        m_count = n_count;
        m_cmp   = n_cmp;
        m_ctrl  = n_ctrl;
        m_match = n_match;
        m_deb   = n_deb;
        check("rd_data", DmemRdData, m_rd);
        check("io_sel", 32'(IoSel), 32'(m_iosel));
        check("led", 32'(Led), 32'(m_led));
        check("irq", 32'(TimerIrq), 32'(m_match & m_ctrl[2]));
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        DmemAddr   = a;
        DmemWrite  = we;
        DmemWrData = d;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, 1'b1, d);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(a, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] e;
        m_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_rd", DmemRdData, 32'h0);
        check("rst_iosel", 32'(IoSel), 32'h0);
        check("rst_led", 32'(Led), 32'h0);
        check("rst_irq", 32'(TimerIrq), 32'h0);
        Rst = 1'b0;
        rd(A_CMP);
        check("rst_cmp", DmemRdData, 32'hFFFF_FFFF);

        // LED store/load and a miss
        wr(A_LED, 32'h1234_56C3);
        check("led_c3", 32'(Led), 32'h0000_00C3);
        rd(A_LED);
        check("led_rd", DmemRdData, 32'h0000_00C3);
        check("led_iosel", 32'(IoSel), 32'h1);
        rd(32'h0000_0040);
        check("miss_iosel", 32'(IoSel), 32'h0);
        check("miss_rd", DmemRdData, 32'h0);

        // Auto-reload timer and W1C interplay
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 12; i++) begin
            rd(A_COUNT);
            check("ar_seq", DmemRdData, 32'(i % 6));
            check("ar_irq", 32'(TimerIrq), 32'(i >= 5));
        end
        wr(A_STATUS, 32'h1);
        check("w1c_clr", 32'(TimerIrq), 32'h0);
        idle(4);
        wr(A_STATUS, 32'h1);
        check("w1c_vs_set", 32'(TimerIrq), 32'h1);

        // Wrap-around and COUNT store while running
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_CMP, 32'd3);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 6; i++) begin
            rd(A_COUNT);
            e = 32'hFFFF_FFFE + 32'(i);
            check("wrap_seq", DmemRdData, e);
        end
        rd(A_STATUS);
        check("wrap_match", DmemRdData, 32'h1);
        wr(A_COUNT, 32'd100);
        rd(A_COUNT);
        check("cnt_store", DmemRdData, 32'd100);
        rd(A_COUNT);
        check("cnt_inc", DmemRdData, 32'd101);

        // Debounce: chatter never accepted, then steady value after 2+16 edges
        for (int k = 0; k < 10; k++) begin
            Switch = (k % 2 == 1) ? 8'h00 : 8'h0F;
            for (int j = 0; j < 3; j++) begin
                rd(A_SWITCH);
                check("deb_chatter", DmemRdData, 32'h0);
            end
        end
        Switch = 8'h0F;
        for (int t = 1; t <= 22; t++) begin
            rd(A_SWITCH);
            check("deb_hold", DmemRdData, (t >= 19) ? 32'h0F : 32'h0);
        end

        // Unmapped offset
        wr(BASE + 32'h20, 32'hDEAD_BEEF);
        rd(BASE + 32'h20);
        check("unmapped", DmemRdData, 32'h0);
        rd(A_CMP);
        rd(A_CTRL);

        // Asynchronous reset mid-cycle
        wr(A_LED, 32'h0000_00A5);
        wr(A_CTRL, 32'h1);
        idle(3);
        rd(A_LED);
        #2;
        Rst = 1'b1;
        #1;
        check("arst_led", 32'(Led), 32'h0);
        check("arst_iosel", 32'(IoSel), 32'h0);
        check("arst_rd", DmemRdData, 32'h0);
        check("arst_irq", 32'(TimerIrq), 32'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        m_reset();
        rd(A_CMP);
        check("arst_cmp", DmemRdData, 32'hFFFF_FFFF);
        rd(A_COUNT);
        check("arst_count", DmemRdData, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, d;
            if ($urandom_range(0, 24) == 0) Switch = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = {BASE[31:8], 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            drive(a, 1'($urandom), d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
